// File: rtl/registro_id_ex_pkg.sv
// Shared decode/execute definitions: opcodes, control-bundle bit positions and the
// bundle type used by the control unit, the ID/EX register and the EXE/MEM stages.
package registro_id_ex_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_0001 = 4'b0001;
    localparam logic [3:0] OP_0010 = 4'b0010;
    localparam logic [3:0] OP_0011 = 4'b0011;
    localparam logic [3:0] OP_0100 = 4'b0100;
    localparam logic [3:0] OP_0101 = 4'b0101;
    localparam logic [3:0] OP_0110 = 4'b0110;
    localparam logic [3:0] OP_0111 = 4'b0111;
    localparam logic [3:0] OP_1000 = 4'b1000;
    localparam logic [3:0] OP_1001 = 4'b1001;
    localparam logic [3:0] OP_1010 = 4'b1010;
    localparam logic [3:0] OP_1011 = 4'b1011;
    localparam logic [3:0] OP_1100 = 4'b1100;
    localparam logic [3:0] OP_1101 = 4'b1101;
    localparam logic [3:0] OP_1110 = 4'b1110;
    localparam logic [3:0] OP_1111 = 4'b1111;

    // Vector load: the only opcode whose result is not forwardable from EXE.
    localparam logic [3:0] OP_VLOAD = OP_0011;

    localparam int CTRL_REG_RDV  = 15;
    localparam int CTRL_REG_RDS  = 14;
    localparam int CTRL_SEL_DEST = 13;
    localparam int CTRL_SEL_OP   = 12;
    localparam int CTRL_SEL_AD   = 11;
    localparam int CTRL_SEL_INT  = 10;
    localparam int CTRL_SUM_MEM  = 9;
    localparam int CTRL_SEL_MEM  = 8;
    localparam int CTRL_SEL_DATA = 7;
    localparam int CTRL_MEM_WR   = 6;
    localparam int CTRL_SEL_WB   = 5;
    localparam int CTRL_REG_WRV  = 4;
    localparam int CTRL_REG_WRS  = 3;

    typedef logic [15:0] ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = 16'h0000;

    function automatic logic is_vload(input logic valid, input logic [3:0] opcode);
        return valid && (opcode == OP_VLOAD);
    endfunction

endpackage

// File: rtl/registro_id_ex_deteccion_riesgos.sv
// Load-use hazard detection against the load sitting in EX, plus the bubble counter
// that keeps fetch/decode frozen for LOAD_STALL cycles per hazard.
module deteccion_riesgos
    import registro_id_ex_pkg::*;
#(
    parameter int REG_AW     = 3,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_reg_rdv,
    input  logic [REG_AW-1:0] i_src1,
    input  logic [REG_AW-1:0] i_src2,
    input  logic              i_ex_valid,
    input  logic [3:0]        i_ex_opcode,
    input  logic [REG_AW-1:0] i_ex_dst,
    input  logic              i_stall_ex,
    input  logic              i_flush,
    output logic              o_stall_id,
    output logic              o_insert_bubble
);

    localparam logic [2:0] C_STALL_INIT = 3'(LOAD_STALL - 1);

    logic [2:0] r_cnt;
    logic       w_cnt_busy;
    logic       w_haz;

    assign w_cnt_busy = (r_cnt != 3'd0);

    // Only examined while no earlier hazard is still being paid for.
    assign w_haz = !w_cnt_busy && i_valid && i_reg_rdv
                   && is_vload(i_ex_valid, i_ex_opcode)
                   && ((i_ex_dst == i_src1) || (i_ex_dst == i_src2));

    always_comb begin
        o_stall_id      = 1'b0;
        o_insert_bubble = 1'b0;
        if (i_flush) begin
            o_stall_id = 1'b0;
        end else if (i_stall_ex) begin
            o_stall_id = 1'b1;
        end else if (w_cnt_busy || w_haz) begin
            o_stall_id      = 1'b1;
            o_insert_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 3'd0;
        end else if (i_flush) begin
            r_cnt <= 3'd0;
        end else if (i_stall_ex) begin
            r_cnt <= r_cnt;
        end else if (w_cnt_busy) begin
            r_cnt <= r_cnt - 3'd1;
        end else if (w_haz) begin
            r_cnt <= C_STALL_INIT;
        end
    end

endmodule

// File: rtl/registro_id_ex.sv
// ID/EX pipeline register of the vector processor: captures the decoded control
// bundle and register addresses, inserting bubbles on load-use hazards and flushes.
module registro_id_ex
    import registro_id_ex_pkg::*;
#(
    parameter int REG_AW     = 3,
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [3:0]        opcode_in,
    input  logic [15:0]       ctrl_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    input  logic [REG_AW-1:0] dst_in,
    input  logic              stall_ex,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [15:0]       ex_ctrl,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2,
    output logic [REG_AW-1:0] ex_dst,
    output logic              stall_id
);

    logic              r_ex_valid;
    logic [3:0]        r_ex_opcode;
    ctrl_t             r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_src1;
    logic [REG_AW-1:0] r_ex_src2;
    logic [REG_AW-1:0] r_ex_dst;

    logic              w_stall_id;
    logic              w_insert_bubble;
    ctrl_t             w_ctrl_gated;

    deteccion_riesgos #(
        .REG_AW     (REG_AW),
        .LOAD_STALL (LOAD_STALL)
    ) u_deteccion_riesgos (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (valid_in),
        .i_reg_rdv       (ctrl_in[CTRL_REG_RDV]),
        .i_src1          (src1_in),
        .i_src2          (src2_in),
        .i_ex_valid      (r_ex_valid),
        .i_ex_opcode     (r_ex_opcode),
        .i_ex_dst        (r_ex_dst),
        .i_stall_ex      (stall_ex),
        .i_flush         (flush),
        .o_stall_id      (w_stall_id),
        .o_insert_bubble (w_insert_bubble)
    );

    // An empty slot must never carry write enables into EXE/MEM.
    assign w_ctrl_gated = valid_in ? ctrl_in : BUBBLE_CTRL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= OP_NOP;
            r_ex_ctrl   <= BUBBLE_CTRL;
            r_ex_src1   <= '0;
            r_ex_src2   <= '0;
            r_ex_dst    <= '0;
        end else if (flush || w_insert_bubble) begin
            r_ex_valid  <= 1'b0;
            r_ex_opcode <= OP_NOP;
            r_ex_ctrl   <= BUBBLE_CTRL;
            r_ex_src1   <= '0;
            r_ex_src2   <= '0;
            r_ex_dst    <= '0;
        end else if (!stall_ex) begin
            r_ex_valid  <= valid_in;
            r_ex_opcode <= opcode_in;
            r_ex_ctrl   <= w_ctrl_gated;
            r_ex_src1   <= src1_in;
            r_ex_src2   <= src2_in;
            r_ex_dst    <= dst_in;
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_opcode = r_ex_opcode;
    assign ex_ctrl   = r_ex_ctrl;
    assign ex_src1   = r_ex_src1;
    assign ex_src2   = r_ex_src2;
    assign ex_dst    = r_ex_dst;
    assign stall_id  = w_stall_id;

endmodule

// File: tb/tb_registro_id_ex.sv
// Scoreboard bench for registro_id_ex: two instances (LOAD_STALL=1 and 3) share stimulus,
// a reference model pushes expected EX contents each cycle and they are popped after the edge.
module tb_registro_id_ex;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [15:0] ctrl;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  d;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [3:0]  opcode_in;
    logic [15:0] ctrl_in;
    logic [2:0]  src1_in, src2_in, dst_in;
    logic        stall_ex, flush;

    logic        a_v   [2];
    logic [3:0]  a_op  [2];
    logic [15:0] a_ctrl[2];
    logic [2:0]  a_s1  [2];
    logic [2:0]  a_s2  [2];
    logic [2:0]  a_d   [2];
    logic        a_sid [2];

    always #5 clk = ~clk;

    registro_id_ex #(.REG_AW(3), .LOAD_STALL(1)) dut_ls1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode_in(opcode_in),
        .ctrl_in(ctrl_in), .src1_in(src1_in), .src2_in(src2_in), .dst_in(dst_in),
        .stall_ex(stall_ex), .flush(flush), .ex_valid(a_v[0]), .ex_opcode(a_op[0]),
        .ex_ctrl(a_ctrl[0]), .ex_src1(a_s1[0]), .ex_src2(a_s2[0]), .ex_dst(a_d[0]),
        .stall_id(a_sid[0])
    );

    registro_id_ex #(.REG_AW(3), .LOAD_STALL(3)) dut_ls3 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode_in(opcode_in),
        .ctrl_in(ctrl_in), .src1_in(src1_in), .src2_in(src2_in), .dst_in(dst_in),
        .stall_ex(stall_ex), .flush(flush), .ex_valid(a_v[1]), .ex_opcode(a_op[1]),
        .ex_ctrl(a_ctrl[1]), .ex_src1(a_s1[1]), .ex_src2(a_s2[1]), .ex_dst(a_d[1]),
        .stall_id(a_sid[1])
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    ex_t  m    [2];
    logic [2:0] mcnt [2];
    int   ls   [2];
    int   stall_hi [2];
    ex_t  q0[$];
    ex_t  q1[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic ex_t act_ex(input int k);
        return {a_v[k], a_op[k], a_ctrl[k], a_s1[k], a_s2[k], a_d[k]};
    endfunction

    function automatic logic model_haz(input int k);
        return (mcnt[k] == 3'd0) && valid_in && ctrl_in[15] && m[k].v
               && (m[k].op == 4'b0011) && (m[k].d == src1_in || m[k].d == src2_in);
    endfunction

    function automatic logic model_stall(input int k);
        if (flush) return 1'b0;
        if (stall_ex) return 1'b1;
        return (mcnt[k] != 3'd0) || model_haz(k);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k] = '0;
            mcnt[k] = 3'd0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [15:0] c,
                          input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
        valid_in = v; opcode_in = op; ctrl_in = c;
        src1_in = s1; src2_in = s2; dst_in = d;
    endtask

    // One clock: check combinational stall_id, advance model, compare EX after the edge.
    task automatic step();
        ex_t e;
        logic h;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stall_id_ls%0d", ls[k]), 32'(a_sid[k]), 32'(model_stall(k)));
            if (a_sid[k]) stall_hi[k]++;
            h = model_haz(k);
            if (flush) begin
                m[k] = '0; mcnt[k] = 3'd0;
            end else if (stall_ex) begin
                m[k] = m[k];
            end else if (mcnt[k] != 3'd0) begin
                m[k] = '0; mcnt[k] = mcnt[k] - 3'd1;
            end else if (h) begin
                m[k] = '0; mcnt[k] = 3'(ls[k] - 1);
            end else begin
                m[k] = {valid_in, opcode_in, (valid_in ? ctrl_in : 16'h0000),
                        src1_in, src2_in, dst_in};
            end
            if (k == 0) q0.push_back(m[k]); else q1.push_back(m[k]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                chk($sformatf("sb_empty_ls%0d", ls[k]), 32'd0, 32'd1);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("ex_ls%0d", ls[k]), 32'(act_ex(k)), 32'(e));
            end
        end
    endtask

    task automatic clr_stall_cnt();
        stall_hi[0] = 0;
        stall_hi[1] = 0;
    endtask

    task automatic rand_id();
        set_id(1'($urandom), 4'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    endtask

    localparam logic [15:0] C_LOAD = 16'h0110;  // sel_mem + reg_wrv
    localparam logic [15:0] C_ALU  = 16'h8030;  // reg_rdv + sel_wb + reg_wrv
    localparam logic [15:0] C_SCAL = 16'h4008;  // reg_rds + reg_wrs, no vector read

    initial begin
        ls[0] = 1; ls[1] = 3;
        stall_ex = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        clr_stall_cnt();

        // Reset holds everything at zero whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            rand_id();
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("rst_ex", 32'(act_ex(k)), 32'd0);
                chk("rst_stall_id", 32'(a_sid[k]), 32'd0);
            end
        end
        rst_n = 1'b1;
        step();

        // Pass-through.
        set_id(1'b1, 4'b0001, C_ALU, 3'd1, 3'd0, 3'd4);
        step();
        step();

        // Non-valid slot: control forced to zero.
        set_id(1'b0, 4'b0011, 16'hFFFF, 3'd2, 3'd3, 3'd5);
        step();

        // Load-use: LOAD_STALL=1 stalls once, LOAD_STALL=3 stalls three times.
        set_id(1'b1, 4'b0011, C_LOAD, 3'd0, 3'd0, 3'd2);
        step();
        clr_stall_cnt();
        set_id(1'b1, 4'b0001, C_ALU, 3'd2, 3'd0, 3'd6);
        for (int i = 0; i < 4; i++) step();
        chk("loaduse_cycles_ls1", 32'(stall_hi[0]), 32'd1);
        chk("loaduse_cycles_ls3", 32'(stall_hi[1]), 32'd3);

        // No false hazard: different addresses, then no vector read.
        set_id(1'b1, 4'b0011, C_LOAD, 3'd0, 3'd0, 3'd2);
        step();
        clr_stall_cnt();
        set_id(1'b1, 4'b0001, C_ALU, 3'd3, 3'd5, 3'd1);
        step();
        set_id(1'b1, 4'b0011, C_LOAD, 3'd0, 3'd0, 3'd2);
        step();
        set_id(1'b1, 4'b1100, C_SCAL, 3'd2, 3'd2, 3'd1);
        step();
        chk("nofalse_cycles_ls1", 32'(stall_hi[0]), 32'd0);
        chk("nofalse_cycles_ls3", 32'(stall_hi[1]), 32'd0);

        // Flush in the 2nd stall cycle clears the counter.
        set_id(1'b1, 4'b0011, C_LOAD, 3'd0, 3'd0, 3'd2);
        step();
        clr_stall_cnt();
        set_id(1'b1, 4'b0001, C_ALU, 3'd2, 3'd0, 3'd6);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        chk("flush_cycles_ls3", 32'(stall_hi[1]), 32'd1);

        // Hold in the middle of a stall: counter frozen for 4 cycles.
        set_id(1'b1, 4'b0011, C_LOAD, 3'd0, 3'd0, 3'd2);
        step();
        clr_stall_cnt();
        set_id(1'b1, 4'b0001, C_ALU, 3'd0, 3'd2, 3'd6);
        step();
        stall_ex = 1'b1;
        for (int i = 0; i < 4; i++) step();
        stall_ex = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("hold_cycles_ls1", 32'(stall_hi[0]), 32'd5);
        chk("hold_cycles_ls3", 32'(stall_hi[1]), 32'd7);

        // Hold plus flush: flush wins.
        stall_ex = 1'b1; flush = 1'b1;
        step();
        stall_ex = 1'b0; flush = 1'b0;

        // Async reset between edges during a hazard stall.
        set_id(1'b1, 4'b0011, C_LOAD, 3'd0, 3'd0, 3'd2);
        step();
        set_id(1'b1, 4'b0001, C_ALU, 3'd2, 3'd0, 3'd6);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_ex", 32'(act_ex(k)), 32'd0);
            chk("async_rst_stall_id", 32'(a_sid[k]), 32'd0);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        clr_stall_cnt();
        step();
        chk("post_rst_cycles_ls3", 32'(stall_hi[1]), 32'd0);

        // Random traffic biased towards loads and matching addresses.
        for (int i = 0; i < 60; i++) begin
            rand_id();
            if ($urandom_range(0, 2) == 0) opcode_in = 4'b0011;
            if ($urandom_range(0, 1) == 0) src1_in = dst_in;
            flush    = ($urandom_range(0, 9) == 0);
            stall_ex = ($urandom_range(0, 5) == 0);
            step();
        end
        flush = 1'b0; stall_ex = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
